lcd_lfsr_display: RTL and testbench

Downstream display stage for the LFSR generator/checker top. It latches one 16-bit LFSR word and the lock flag, converts the word to four ASCII hex characters, and writes them to an HD44780-compatible character LCD over a 4-bit parallel bus. It owns the LCD power-up and initialisation sequence, and all bus timing is derived from cycle counters at the system clock (10 MHz nominal).

---
 rtl/lcd_lfsr_display_if.sv | 22 ++
 rtl/lcd_lfsr_display.sv | 251 +++++++++++++++++++++++++
 tb/tb_lcd_lfsr_display.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_lfsr_display_if.sv
// Bus bundle between the LFSR top and the LCD display stage:
// sample strobe/data on the input side, the 4-bit LCD bus and status on the output side.
interface lcd_lfsr_display_if;
  logic [15:0] i_data;
  logic        i_lock;
  logic        i_valid;
  logic        o_lcd_rs;
  logic        o_lcd_e;
  logic [3:0]  o_lcd_d;
  logic        o_busy;
  logic        o_init_done;

  modport master (
    output i_data, i_lock, i_valid,
    input  o_lcd_rs, o_lcd_e, o_lcd_d, o_busy, o_init_done
  );

  modport slave (
    input  i_data, i_lock, i_valid,
    output o_lcd_rs, o_lcd_e, o_lcd_d, o_busy, o_init_done
  );
endinterface

// File: rtl/lcd_lfsr_display.sv
// HD44780 4-bit display stage: power-up/init sequence, then shows a latched
// 16-bit LFSR word as four ASCII hex characters on each accepted capture.
// Optional feature macro LCD_LOCK_CHAR_EN appends " L"/" U" (lock state).
// All LCD bus outputs are registered from the current state, so they trail
// the state register by one cycle.
module lcd_lfsr_display #(
  parameter int unsigned E_PULSE_CYC    = 5,
  parameter int unsigned NIBBLE_GAP_CYC = 10,
  parameter int unsigned CMD_WAIT_CYC   = 400,
  parameter int unsigned CLEAR_WAIT_CYC = 16000,
  parameter int unsigned POWERUP_CYC    = 150000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_soft_reset,
  lcd_lfsr_display_if.slave bus
);

  localparam int unsigned NIB_SLOT = 1 + E_PULSE_CYC + NIBBLE_GAP_CYC;
  localparam int unsigned NIB_W    = $clog2(NIB_SLOT + 1);
  localparam int unsigned MAX_A    = (POWERUP_CYC > CLEAR_WAIT_CYC) ? POWERUP_CYC : CLEAR_WAIT_CYC;
  localparam int unsigned DLY_MAX  = (MAX_A > CMD_WAIT_CYC) ? MAX_A : CMD_WAIT_CYC;
  localparam int unsigned DLY_W    = $clog2(DLY_MAX + 1);

  // Nibble counter runs NIB_SLOT-1 (setup) down to 0; E is high in between.
  localparam logic [NIB_W-1:0] NIB_LAST = NIB_W'(NIB_SLOT - 1);
  localparam logic [NIB_W-1:0] E_FIRST  = NIB_W'(E_PULSE_CYC + NIBBLE_GAP_CYC - 1);
  localparam logic [NIB_W-1:0] E_LAST   = NIB_W'(NIBBLE_GAP_CYC);

  localparam logic [DLY_W-1:0] PWR_LOAD   = DLY_W'(POWERUP_CYC - 1);
  localparam logic [DLY_W-1:0] CMD_LOAD   = DLY_W'(CMD_WAIT_CYC - 1);
  localparam logic [DLY_W-1:0] CLEAR_LOAD = DLY_W'(CLEAR_WAIT_CYC - 1);

`ifdef LCD_LOCK_CHAR_EN
  localparam int unsigned REF_LEN = 7;
`else
  localparam int unsigned REF_LEN = 5;
`endif
  localparam logic [2:0] INIT_LAST = 3'd7;
  localparam logic [2:0] REF_LAST  = 3'(REF_LEN - 1);

  typedef enum logic [2:0] {
    S_PWR, S_INIT, S_IDLE, S_SEND_HI, S_SEND_LO, S_WAIT
  } state_t;

  // One LCD transfer: register select, single-nibble flag (init only), byte value.
  typedef struct packed {
    logic       rs;
    logic       single;
    logic [7:0] val;
  } step_t;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    hex_ascii = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  state_t           state, state_n;
  logic [NIB_W-1:0] nib_cnt, nib_n;
  logic [DLY_W-1:0] dly_cnt, dly_n;
  logic [2:0]       step_idx, idx_n, sel_idx;
  logic             in_init, init_n, sel_init;
  step_t            cur, cur_n, desc;
  logic [15:0]      data_q, data_n;
  logic             idle_q, idle_n;
  logic             send, last_step;
  logic             e_n, rs_n, busy_n, done_n;
  logic [3:0]       d_n;
`ifdef LCD_LOCK_CHAR_EN
  logic             lock_q, lock_n;
`else
  logic             unused_lock;
  assign unused_lock = bus.i_lock;
`endif

  // Descriptor of the transfer the FSM loads next (first init step, first refresh step, or successor)
  always_comb begin
    sel_init = in_init;
    sel_idx  = step_idx + 3'd1;
    if (state == S_INIT) begin
      sel_init = 1'b1;
      sel_idx  = '0;
    end else if (state == S_IDLE) begin
      sel_init = 1'b0;
      sel_idx  = '0;
    end
    desc = '{rs: 1'b0, single: 1'b0, val: 8'h00};
    if (sel_init) begin
      case (sel_idx)
        3'd0, 3'd1, 3'd2: desc = '{rs: 1'b0, single: 1'b1, val: 8'h03};
        3'd3:             desc = '{rs: 1'b0, single: 1'b1, val: 8'h02};
        3'd4:             desc = '{rs: 1'b0, single: 1'b0, val: 8'h28};
        3'd5:             desc = '{rs: 1'b0, single: 1'b0, val: 8'h0C};
        3'd6:             desc = '{rs: 1'b0, single: 1'b0, val: 8'h06};
        default:          desc = '{rs: 1'b0, single: 1'b0, val: 8'h01};
      endcase
    end else begin
      case (sel_idx)
        3'd0:    desc = '{rs: 1'b0, single: 1'b0, val: 8'h80};
        3'd1:    desc = '{rs: 1'b1, single: 1'b0, val: hex_ascii(data_q[15:12])};
        3'd2:    desc = '{rs: 1'b1, single: 1'b0, val: hex_ascii(data_q[11:8])};
        3'd3:    desc = '{rs: 1'b1, single: 1'b0, val: hex_ascii(data_q[7:4])};
        3'd4:    desc = '{rs: 1'b1, single: 1'b0, val: hex_ascii(data_q[3:0])};
`ifdef LCD_LOCK_CHAR_EN
        3'd5:    desc = '{rs: 1'b1, single: 1'b0, val: 8'h20};
        3'd6:    desc = '{rs: 1'b1, single: 1'b0, val: lock_q ? 8'h4C : 8'h55};
`endif
        default: desc = '{rs: 1'b0, single: 1'b0, val: 8'h00};
      endcase
    end
  end

  // Next-state, counters and registered-output values; soft reset overrides everything last
  always_comb begin
    state_n   = state;
    nib_n     = nib_cnt;
    dly_n     = dly_cnt;
    idx_n     = step_idx;
    init_n    = in_init;
    cur_n     = cur;
    data_n    = data_q;
`ifdef LCD_LOCK_CHAR_EN
    lock_n    = lock_q;
`endif
    last_step = in_init ? (step_idx == INIT_LAST) : (step_idx == REF_LAST);

    case (state)
      S_PWR: begin
        if (dly_cnt == '0) state_n = S_INIT;
        else               dly_n   = dly_cnt - DLY_W'(1);
      end
      S_INIT: begin
        init_n  = 1'b1;
        idx_n   = '0;
        cur_n   = desc;
        nib_n   = NIB_LAST;
        state_n = desc.single ? S_SEND_LO : S_SEND_HI;
      end
      S_IDLE: begin
        if (bus.i_valid && !bus.o_busy) begin
          data_n  = bus.i_data;
`ifdef LCD_LOCK_CHAR_EN
          lock_n  = bus.i_lock;
`endif
          init_n  = 1'b0;
          idx_n   = '0;
          cur_n   = desc;
          nib_n   = NIB_LAST;
          state_n = S_SEND_HI;
        end
      end
      S_SEND_HI: begin
        if (nib_cnt == '0) begin
          state_n = S_SEND_LO;
          nib_n   = NIB_LAST;
        end else begin
          nib_n   = nib_cnt - NIB_W'(1);
        end
      end
      S_SEND_LO: begin
        if (nib_cnt == '0) begin
          state_n = S_WAIT;
          dly_n   = (cur.val == 8'h01 && !cur.rs && !cur.single) ? CLEAR_LOAD : CMD_LOAD;
        end else begin
          nib_n   = nib_cnt - NIB_W'(1);
        end
      end
      S_WAIT: begin
        if (dly_cnt != '0) begin
          dly_n   = dly_cnt - DLY_W'(1);
        end else if (last_step) begin
          state_n = S_IDLE;
        end else begin
          idx_n   = step_idx + 3'd1;
          cur_n   = desc;
          nib_n   = NIB_LAST;
          state_n = desc.single ? S_SEND_LO : S_SEND_HI;
        end
      end
      default: state_n = S_PWR;
    endcase

    send   = (state == S_SEND_HI) || (state == S_SEND_LO);
    e_n    = send && (nib_cnt <= E_FIRST) && (nib_cnt >= E_LAST);
    rs_n   = send ? cur.rs : bus.o_lcd_rs;
    d_n    = (state == S_SEND_HI) ? cur.val[7:4] :
             (state == S_SEND_LO) ? cur.val[3:0] : bus.o_lcd_d;
    // busy drops only after a full cycle in S_IDLE, one cycle after the last wait
    busy_n = !((state == S_IDLE) && idle_q);
    idle_n = (state == S_IDLE);
    done_n = bus.o_init_done || (state == S_IDLE);

    if (i_soft_reset) begin
      state_n = S_PWR;
      dly_n   = PWR_LOAD;
      nib_n   = '0;
      idx_n   = '0;
      init_n  = 1'b1;
      cur_n   = '0;
      data_n  = '0;
`ifdef LCD_LOCK_CHAR_EN
      lock_n  = 1'b0;
`endif
      e_n     = 1'b0;
      rs_n    = 1'b0;
      d_n     = '0;
      busy_n  = 1'b1;
      idle_n  = 1'b0;
      done_n  = 1'b0;
    end
  end

  // State, counters, latched sample and registered LCD/status outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state           <= S_PWR;
      dly_cnt         <= PWR_LOAD;
      nib_cnt         <= '0;
      step_idx        <= '0;
      in_init         <= 1'b1;
      cur             <= '0;
      data_q          <= '0;
`ifdef LCD_LOCK_CHAR_EN
      lock_q          <= 1'b0;
`endif
      idle_q          <= 1'b0;
      bus.o_lcd_e     <= 1'b0;
      bus.o_lcd_rs    <= 1'b0;
      bus.o_lcd_d     <= '0;
      bus.o_busy      <= 1'b1;
      bus.o_init_done <= 1'b0;
    end else begin
      state           <= state_n;
      dly_cnt         <= dly_n;
      nib_cnt         <= nib_n;
      step_idx        <= idx_n;
      in_init         <= init_n;
      cur             <= cur_n;
      data_q          <= data_n;
`ifdef LCD_LOCK_CHAR_EN
      lock_q          <= lock_n;
`endif
      idle_q          <= idle_n;
      bus.o_lcd_e     <= e_n;
      bus.o_lcd_rs    <= rs_n;
      bus.o_lcd_d     <= d_n;
      bus.o_busy      <= busy_n;
      bus.o_init_done <= done_n;
    end
  end

endmodule

// File: tb/tb_lcd_lfsr_display.sv
// Self-checking bench for lcd_lfsr_display: a negedge monitor pops expected
// {RS,D} nibbles from a scoreboard queue on every E rise; captures come from a
// vector table, reset/busy corner cases are hand-written sequences.
module tb_lcd_lfsr_display;

  localparam int unsigned PWR       = 100;
  localparam int unsigned CMDW      = 20;
  localparam int unsigned CLRW      = 50;
  localparam int unsigned NIB       = 16;
  localparam int unsigned BYTE_SLOT = 2 * NIB + CMDW;
`ifdef LCD_LOCK_CHAR_EN
  localparam int unsigned REF_BYTES = 7;
`else
  localparam int unsigned REF_BYTES = 5;
`endif

  logic clk = 1'b0;
  logic rst;
  logic soft_rst;

  lcd_lfsr_display_if bus ();

  lcd_lfsr_display #(
    .POWERUP_CYC   (PWR),
    .CMD_WAIT_CYC  (CMDW),
    .CLEAR_WAIT_CYC(CLRW)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_soft_reset(soft_rst),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard of expected {rs, d} nibbles
  logic [4:0]  exp_q[$];
  logic [4:0]  exp_nib;
  logic [4:0]  rise_val = '0;
  logic        prev_e = 1'b0;
  bit          mon_ignore = 1'b0;
  int unsigned e_rise_cnt = 0;

  always @(negedge clk) begin
    if (bus.o_lcd_e === 1'b1 && prev_e == 1'b0) begin
      rise_val = {bus.o_lcd_rs, bus.o_lcd_d};
      e_rise_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected nibble", {27'b0, rise_val}, 32'hFFFF_FFFF);
      end else begin
        exp_nib = exp_q.pop_front();
        check("nibble {rs,d}", {27'b0, rise_val}, {27'b0, exp_nib});
      end
    end else if (bus.o_lcd_e === 1'b0 && prev_e == 1'b1 && !mon_ignore) begin
      check("rs/d held across E pulse", {27'b0, bus.o_lcd_rs, bus.o_lcd_d}, {27'b0, rise_val});
    end
    prev_e = (bus.o_lcd_e === 1'b1);
  end

  task automatic push_nib(input logic rs, input logic [3:0] n);
    exp_q.push_back({rs, n});
  endtask

  task automatic push_byte(input logic rs, input logic [7:0] b);
    push_nib(rs, b[7:4]);
    push_nib(rs, b[3:0]);
  endtask

  task automatic push_init();
    push_nib(1'b0, 4'h3);
    push_nib(1'b0, 4'h3);
    push_nib(1'b0, 4'h3);
    push_nib(1'b0, 4'h2);
    push_byte(1'b0, 8'h28);
    push_byte(1'b0, 8'h0C);
    push_byte(1'b0, 8'h06);
    push_byte(1'b0, 8'h01);
  endtask

  task automatic wait_idle(input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (bus.o_busy === 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
    check({name, " busy falls within budget"}, {31'b0, seen}, 32'd1);
  endtask

  task automatic wait_first_rise(input string name);
    int unsigned cyc = 0;
    bit seen = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      cyc++;
      if (bus.o_lcd_e === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check({name, " first E after power-up wait"},
          {31'b0, (seen && cyc >= PWR && cyc <= PWR + 5)}, 32'd1);
  endtask

  task automatic init_done_checks(input string name);
    wait_idle(name);
    check({name, " init_done"}, {31'b0, bus.o_init_done}, 32'd1);
    repeat (5) @(negedge clk);
    check({name, " scoreboard drained"}, exp_q.size(), 32'd0);
  endtask

  // Drive a one-cycle capture and queue its expected refresh; returns at negedge after edge N
  task automatic start_capture(input logic [15:0] d, input logic l, input logic [31:0] chars);
    @(negedge clk);
    bus.i_data  = d;
    bus.i_lock  = l;
    bus.i_valid = 1'b1;
    push_byte(1'b0, 8'h80);
    for (int k = 0; k < 4; k++) push_byte(1'b1, chars[31 - 8 * k -: 8]);
`ifdef LCD_LOCK_CHAR_EN
    push_byte(1'b1, 8'h20);
    push_byte(1'b1, l ? 8'h4C : 8'h55);
`endif
    @(posedge clk);
    @(negedge clk);
    bus.i_valid = 1'b0;
  endtask

  task automatic run_capture(input logic [15:0] d, input logic l, input logic [31:0] chars);
    int unsigned busy_cyc;
    bit fell = 1'b0;
    start_capture(d, l, chars);
    @(negedge clk);
    check("busy at N+1", {31'b0, bus.o_busy}, 32'd1);
    check("rs at N+1", {31'b0, bus.o_lcd_rs}, 32'd0);
    check("d at N+1", {28'b0, bus.o_lcd_d}, 32'h8);
    check("e low at N+1", {31'b0, bus.o_lcd_e}, 32'd0);
    busy_cyc = 1;
    @(negedge clk);
    check("e rises at N+2", {31'b0, bus.o_lcd_e}, 32'd1);
    busy_cyc = 2;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (bus.o_busy === 1'b1) busy_cyc++;
      else begin
        fell = 1'b1;
        break;
      end
    end
    check("busy falls", {31'b0, fell}, 32'd1);
    check("busy length", busy_cyc, REF_BYTES * BYTE_SLOT + 1);
    repeat (5) @(negedge clk);
    check("refresh drained", exp_q.size(), 32'd0);
  endtask

  task automatic wait_e_high(input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (bus.o_lcd_e === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({name, " E high seen"}, {31'b0, seen}, 32'd1);
  endtask

  typedef struct {
    logic [15:0] data;
    logic        lock;
    logic [31:0] chars;
  } vec_t;

  vec_t vecs[5];
  int unsigned rises_before;

  initial begin
    vecs[0] = '{data: 16'h012C, lock: 1'b1, chars: "012C"};
    vecs[1] = '{data: 16'hFA09, lock: 1'b0, chars: "FA09"};
    vecs[2] = '{data: 16'h0000, lock: 1'b1, chars: "0000"};
    vecs[3] = '{data: 16'hFFFF, lock: 1'b0, chars: "FFFF"};
    vecs[4] = '{data: 16'h9A5B, lock: 1'b1, chars: "9A5B"};

    rst         = 1'b1;
    soft_rst    = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    bus.i_lock  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset e", {31'b0, bus.o_lcd_e}, 32'd0);
    check("reset rs", {31'b0, bus.o_lcd_rs}, 32'd0);
    check("reset d", {28'b0, bus.o_lcd_d}, 32'd0);
    check("reset busy", {31'b0, bus.o_busy}, 32'd1);
    check("reset init_done", {31'b0, bus.o_init_done}, 32'd0);

    // Power-up init
    push_init();
    rst = 1'b0;
    wait_first_rise("power-up");
    init_done_checks("power-up");

    // Table-driven captures
    for (int i = 0; i < 5; i++) run_capture(vecs[i].data, vecs[i].lock, vecs[i].chars);

    // Capture while busy is ignored
    rises_before = e_rise_cnt;
    start_capture(16'h012C, 1'b1, "012C");
    repeat (40) @(negedge clk);
    check("busy before second strobe", {31'b0, bus.o_busy}, 32'd1);
    bus.i_data  = 16'hBEEF;
    bus.i_lock  = 1'b0;
    bus.i_valid = 1'b1;
    @(negedge clk);
    bus.i_valid = 1'b0;
    wait_idle("busy-capture");
    repeat (60) @(negedge clk);
    check("busy-capture drained", exp_q.size(), 32'd0);
    check("busy-capture E pulses", e_rise_cnt - rises_before, 2 * REF_BYTES);

    // Async reset while E is high
    start_capture(16'hFA09, 1'b0, "FA09");
    wait_e_high("async");
    mon_ignore = 1'b1;
    rst = 1'b1;
    #1;
    check("async rst e", {31'b0, bus.o_lcd_e}, 32'd0);
    check("async rst busy", {31'b0, bus.o_busy}, 32'd1);
    check("async rst init_done", {31'b0, bus.o_init_done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    push_init();
    #1 mon_ignore = 1'b0;
    wait_first_rise("async replay");
    init_done_checks("async replay");

    // Soft reset while E is high: takes effect at the next edge
    start_capture(16'h012C, 1'b1, "012C");
    wait_e_high("soft");
    mon_ignore = 1'b1;
    soft_rst = 1'b1;
    @(posedge clk);
    #1;
    check("soft rst e", {31'b0, bus.o_lcd_e}, 32'd0);
    check("soft rst busy", {31'b0, bus.o_busy}, 32'd1);
    check("soft rst init_done", {31'b0, bus.o_init_done}, 32'd0);
    @(negedge clk);
    soft_rst = 1'b0;
    exp_q.delete();
    push_init();
    #1 mon_ignore = 1'b0;
    wait_first_rise("soft replay");
    init_done_checks("soft replay");

    // Refresh after reset replay
    run_capture(vecs[1].data, vecs[1].lock, vecs[1].chars);

    repeat (10) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
